// File: rtl/lcd_chrono_if.sv
// Chronometer display bus: BCD time and lap flag in,
// HD44780 8-bit parallel bus and frame status out.
interface lcd_chrono_if;
    logic [15:0] time_bcd;
    logic        lap_flag;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic        busy;
    logic        frame_done;

    modport master (
        input  time_bcd, lap_flag,
        output lcd_data, lcd_rs, lcd_rw, lcd_e,
        output busy, frame_done
    );

    modport slave (
        output time_bcd, lap_flag,
        input  lcd_data, lcd_rs, lcd_rw, lcd_e,
        input  busy, frame_done
    );
endinterface

// File: rtl/lcd_chrono_writer.sv
// HD44780 writer for the chronometer: power-up init, then
// rewrites line 1 as "SS.hh" plus lap marker on any change.
module lcd_chrono_writer #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned POWERUP_US = 20000,
    parameter int unsigned CMD_US     = 50,
    parameter int unsigned CLEAR_US   = 2000,
    parameter int unsigned E_PULSE    = 25
) (
    input  logic clk_in,
    input  logic reset,
    lcd_chrono_if.master bus
);
    localparam int unsigned PWR_CYC = POWERUP_US * CLK_PER_US;
    localparam int unsigned CMD_CYC = CMD_US * CLK_PER_US;
    localparam int unsigned CLR_CYC = CLEAR_US * CLK_PER_US;
    localparam int unsigned M1 =
        (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int unsigned M2 = (M1 > CMD_CYC) ? M1 : CMD_CYC;
    localparam int unsigned M3 = (M2 > E_PULSE) ? M2 : E_PULSE;
    localparam int CW = $clog2(M3 + 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_SETUP, S_EHI, S_WAIT, S_IDLE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_frame;
    logic [16:0]   r_snap;
    logic [16:0]   r_last;
    logic          r_valid;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_e;
    logic          r_busy;
    logic          r_done;

    logic [16:0]   w_cur;
    logic [7:0]    w_byte;
    logic          w_rs;
    logic          w_clr;

    assign w_cur = {bus.time_bcd, bus.lap_flag};
    assign w_clr = !r_frame && (r_idx == 3'd5);

    function automatic logic [7:0] digit(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Byte and register-select for the write at (r_frame, r_idx)
    always_comb begin
        w_byte = 8'h00;
        w_rs   = 1'b0;
        if (!r_frame) begin
            unique case (r_idx)
                3'd0, 3'd1, 3'd2: w_byte = 8'h38;
                3'd3:             w_byte = 8'h0C;
                3'd4:             w_byte = 8'h06;
                default:          w_byte = 8'h01;
            endcase
        end else begin
            w_rs = (r_idx != 3'd0);
            unique case (r_idx)
                3'd0:    w_byte = 8'h80;
                3'd1:    w_byte = digit(r_snap[16:13]);
                3'd2:    w_byte = digit(r_snap[12:9]);
                3'd3:    w_byte = 8'h2E;
                3'd4:    w_byte = digit(r_snap[8:5]);
                3'd5:    w_byte = digit(r_snap[4:1]);
                3'd6:    w_byte = 8'h20;
                default: w_byte = r_snap[0] ? 8'h4C : 8'h20;
            endcase
        end
    end

    // Sequencer: power-up wait, init list, idle compare, frames
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_PWRUP;
            r_cnt   <= CW'(PWR_CYC - 1);
            r_idx   <= 3'd0;
            r_frame <= 1'b0;
            r_snap  <= '0;
            r_last  <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_PWRUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SETUP;
                        r_idx   <= 3'd0;
                        r_frame <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SETUP: begin
                    r_data  <= w_byte;
                    r_rs    <= w_rs;
                    r_cnt   <= CW'(E_PULSE);
                    r_state <= S_EHI;
                end
                S_EHI: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b0;
                        r_cnt   <= w_clr ? CW'(CLR_CYC - 1)
                                         : CW'(CMD_CYC - 1);
                        r_state <= S_WAIT;
                    end else begin
                        r_e   <= 1'b1;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_clr) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_frame && r_idx == 3'd7) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_last  <= r_snap;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= S_SETUP;
                    end
                end
                S_IDLE: begin
                    if (!r_valid || w_cur != r_last) begin
                        r_snap  <= w_cur;
                        r_frame <= 1'b1;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                default: r_state <= S_PWRUP;
            endcase
        end
    end

    assign bus.lcd_data   = r_data;
    assign bus.lcd_rs     = r_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = r_e;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_lcd_chrono_writer.sv
// Bench for lcd_chrono_writer: captures every E strobe and
// compares against the expected LCD write stream.
module tb_lcd_chrono_writer;
    localparam int CPU = 2;
    localparam int PU  = 10;
    localparam int CU  = 3;
    localparam int CLU = 8;
    localparam int EP  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lcd_chrono_if bus ();

    lcd_chrono_writer #(
        .CLK_PER_US(CPU),
        .POWERUP_US(PU),
        .CMD_US(CU),
        .CLEAR_US(CLU),
        .E_PULSE(EP)
    ) dut (
        .clk_in(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [8:0] q_got[$];
    int         q_rise[$];
    int         q_fall[$];
    logic [8:0] q_exp[$];

    int cyc = 0;
    int hcnt = 0;
    int fd_cnt = 0;
    logic pe = 1'b0;
    logic pfd = 1'b0;
    logic rst_in_pulse = 1'b0;
    logic stab_bad = 1'b0;
    logic rw_bad = 1'b0;
    logic fd_wide = 1'b0;
    logic [8:0] pdat = '0;
    logic [8:0] rdat = '0;

    // Strobe monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            if (pfd) fd_wide = 1'b1;
        end
        if (bus.lcd_e && !pe) begin
            rdat = {bus.lcd_rs, bus.lcd_data};
            q_got.push_back(rdat);
            q_rise.push_back(cyc);
            hcnt = 0;
            rst_in_pulse = 1'b0;
            stab_bad = (rdat !== pdat);
        end
        if (bus.lcd_e) begin
            hcnt++;
            if ({bus.lcd_rs, bus.lcd_data} !== rdat) stab_bad = 1'b1;
        end
        if (reset) rst_in_pulse = 1'b1;
        if (!bus.lcd_e && pe) begin
            q_fall.push_back(cyc);
            if (!rst_in_pulse) begin
                chk("e_width", hcnt, EP);
                chk("db_stable", {31'b0, stab_bad}, 0);
            end
        end
        pe  = bus.lcd_e;
        pfd = bus.frame_done;
        pdat = {bus.lcd_rs, bus.lcd_data};
    end

    int base = 0;
    int fd_base = 0;
    logic [15:0] cur_t = '0;
    logic        cur_l = 1'b0;

    function automatic logic [8:0] dch(input logic [3:0] d);
        return (d > 4'd9) ? 9'h13F : (9'h130 + 9'(d));
    endfunction

    task automatic exp_init();
        q_exp.push_back(9'h038);
        q_exp.push_back(9'h038);
        q_exp.push_back(9'h038);
        q_exp.push_back(9'h00C);
        q_exp.push_back(9'h006);
        q_exp.push_back(9'h001);
    endtask

    task automatic exp_frame(input logic [15:0] t, input logic lap);
        q_exp.push_back(9'h080);
        q_exp.push_back(dch(t[15:12]));
        q_exp.push_back(dch(t[11:8]));
        q_exp.push_back(9'h12E);
        q_exp.push_back(dch(t[7:4]));
        q_exp.push_back(dch(t[3:0]));
        q_exp.push_back(9'h120);
        q_exp.push_back(lap ? 9'h14C : 9'h120);
    endtask

    task automatic check_exp(input int start);
        logic [8:0] g;
        for (int i = 0; i < q_exp.size(); i++) begin
            g = (start + i < q_got.size()) ? q_got[start + i] : 9'h1FF;
            chk($sformatf("wr%0d", i), {23'b0, g}, {23'b0, q_exp[i]});
        end
        q_exp.delete();
    endtask

    task automatic wait_n(input int n, input int budget);
        int k = 0;
        while (q_got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q_got.size() < n) chk("wr_timeout", q_got.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) chk("idle_timeout", {31'b0, bus.busy}, 0);
    endtask

    // Caller sits on a negedge; reset is applied immediately
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_data", {24'b0, bus.lcd_data}, 0);
        chk("rst_rs", {31'b0, bus.lcd_rs}, 0);
        chk("rst_e", {31'b0, bus.lcd_e}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 1);
        chk("rst_fd", {31'b0, bus.frame_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        base = q_got.size();
        fd_base = fd_cnt;
    endtask

    task automatic boot_check(input logic [15:0] t, input logic lap);
        repeat (20) @(negedge clk);
        chk("pwrup_quiet", q_got.size() - base, 0);
        wait_n(base + 14, 2000);
        exp_init();
        exp_frame(t, lap);
        check_exp(base);
        if (q_rise.size() > base + 6 && q_fall.size() > base + 5)
            chk("clr_gap",
                {31'b0, (q_rise[base + 6] - q_fall[base + 5]) >= 16}, 1);
        else
            chk("clr_gap_missing", q_rise.size(), base + 7);
        wait_idle(500);
        repeat (2) @(negedge clk);
        chk("boot_fd", fd_cnt - fd_base, 1);
        chk("boot_busy", {31'b0, bus.busy}, 0);
    endtask

    task automatic set_in(input logic [15:0] t, input logic lap);
        bus.time_bcd = t;
        bus.lap_flag = lap;
        cur_t = t;
        cur_l = lap;
    endtask

    task automatic frame_case(input logic [15:0] t, input logic lap);
        int b;
        int f;
        @(negedge clk);
        b = q_got.size();
        f = fd_cnt;
        set_in(t, lap);
        wait_n(b + 8, 600);
        exp_frame(t, lap);
        check_exp(b);
        wait_idle(600);
        repeat (2) @(negedge clk);
        chk("frame_fd", fd_cnt - f, 1);
        chk("frame_extra", q_got.size() - b, 8);
    endtask

    initial begin
        logic [15:0] t;
        logic        l;
        int          b;
        int          k;
        set_in(16'h0000, 1'b0);
        @(negedge clk);
        do_reset();
        boot_check(16'h0000, 1'b0);

        frame_case(16'h1234, 1'b0);
        b = q_got.size();
        repeat (1000) @(negedge clk);
        chk("hold_quiet", q_got.size() - b, 0);
        chk("hold_e", {31'b0, bus.lcd_e}, 0);

        frame_case(16'hA0F9, 1'b0);

        for (int i = 0; i < 8; i++) begin
            t = 16'($urandom);
            l = 1'($urandom_range(0, 1));
            if (t == cur_t && l == cur_l) l = ~l;
            frame_case(t, l);
        end

        t = (cur_t == 16'h1111 && !cur_l) ? 16'h2222 : 16'h1111;
        @(negedge clk);
        b = q_got.size();
        set_in(t, 1'b0);
        wait_n(b + 3, 600);
        set_in(16'h5678, 1'b1);
        wait_n(b + 16, 1200);
        exp_frame(t, 1'b0);
        exp_frame(16'h5678, 1'b1);
        check_exp(b);
        wait_idle(600);
        repeat (300) @(negedge clk);
        chk("mid_quiet", q_got.size() - b, 16);

        do_reset();
        wait_n(base + 2, 600);
        k = 0;
        while (bus.lcd_e && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("init_wait_e", {31'b0, bus.lcd_e}, 0);
        do_reset();
        boot_check(16'h5678, 1'b1);

        @(negedge clk);
        b = q_got.size();
        set_in(16'h9012, 1'b0);
        wait_n(b + 3, 600);
        chk("in_strobe", {31'b0, bus.lcd_e}, 1);
        do_reset();
        boot_check(16'h9012, 1'b0);

        chk("rw_zero", {31'b0, rw_bad}, 0);
        chk("fd_width", {31'b0, fd_wide}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
